// File: rtl/channel_accum_relu_if.sv
// Bus between the adder-tree output and the channel accumulator.
// The master drives partial sums and bias. The slave returns the activation
// and the flow-control flags.
interface channel_accum_relu_if #(
    parameter int IN_W   = 22,
    parameter int BIAS_W = 16,
    parameter int OUT_W  = 8
) ();
    logic              enable;
    logic [IN_W-1:0]   input1;
    logic [BIAS_W-1:0] bias;
    logic              ready;
    logic [OUT_W-1:0]  output1;
    logic              done;
    logic              drop;

    modport master (
        output enable, input1, bias,
        input  ready, output1, done, drop
    );

    modport slave (
        input  enable, input1, bias,
        output ready, output1, done, drop
    );
endinterface

// File: rtl/channel_accum_relu.sv
// Channel accumulator with bias, ReLU, round-half-up shift and unsigned saturation.
// It sums NUM_CH signed partial sums and adds the per-filter bias.
// It then emits one OUT_W-bit activation with a single-cycle done pulse.
module channel_accum_relu #(
    parameter int IN_W   = 22,
    parameter int NUM_CH = 4,
    parameter int ACC_W  = 26,
    parameter int BIAS_W = 16,
    parameter int SHIFT  = 8,
    parameter int OUT_W  = 8
) (
    input logic                 clk,
    input logic                 rst,
    channel_accum_relu_if.slave bus
);
    localparam int CNT_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int SUM_W = ACC_W + 1;
    localparam int RND_W = ACC_W + 2;

    typedef enum logic [1:0] {
        ST_ACC  = 2'd0,
        ST_BIAS = 2'd1,
        ST_ACT  = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic signed [SUM_W-1:0]  sum_q, sum_d;
    logic [OUT_W-1:0]         out_q, out_d;
    logic                     done_q, done_d;
    logic                     drop_q, drop_d;

    logic                     ready;
    logic signed [IN_W-1:0]   in_s;
    logic signed [BIAS_W-1:0] bias_s;
    logic signed [ACC_W-1:0]  in_ext;
    logic [RND_W-1:0]         rnd;
    logic [RND_W-1:0]         shifted;
    logic [OUT_W-1:0]         q_val;

    assign ready  = (state_q == ST_ACC);
    assign in_s   = bus.input1;
    assign bias_s = bus.bias;
    assign in_ext = ACC_W'(in_s);

    // The activation function of sum_q.
    // The rounding add uses one spare bit so that it cannot overflow.
    // Negative sums clamp to 0. Large results saturate to the all-ones code.
    always_comb begin
        rnd     = {1'b0, sum_q} + RND_W'(2 ** (SHIFT - 1));
        shifted = rnd >> SHIFT;
        if (sum_q[SUM_W-1]) begin
            q_val = '0;
        end else if (shifted > RND_W'(2 ** OUT_W - 1)) begin
            q_val = '1;
        end else begin
            q_val = shifted[OUT_W-1:0];
        end
    end

    // Next-state and datapath logic for the ACC -> BIAS -> ACT window sequence.
    always_comb begin
        // NOTE: every variable gets a default before the case. Without it, any path
        // that skips an assignment would infer a latch.
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        out_d   = out_q;
        done_d  = 1'b0;
        drop_d  = drop_q | (bus.enable & ~ready);

        case (state_q)
            ST_ACC: begin
                if (bus.enable) begin
                    acc_d = acc_q + in_ext;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(NUM_CH - 1)) begin
                        state_d = ST_BIAS;
                    end
                end
            end
            ST_BIAS: begin
                sum_d   = SUM_W'(acc_q) + SUM_W'(bias_s);
                state_d = ST_ACT;
            end
            ST_ACT: begin
                out_d   = q_val;
                done_d  = 1'b1;
                acc_d   = '0;
                cnt_d   = '0;
                state_d = ST_ACC;
            end
            default: begin
                state_d = ST_ACC;
            end
        endcase
    end

    // State register with synchronous reset. Reset discards any partial window.
    always_ff @(posedge clk) begin
        // NOTE: registers use non-blocking assignments. All of them then update
        // together from values sampled before the edge, regardless of statement order.
        if (rst) begin
            state_q <= ST_ACC;
            acc_q   <= '0;
            cnt_q   <= '0;
            sum_q   <= '0;
            out_q   <= '0;
            done_q  <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            out_q   <= out_d;
            done_q  <= done_d;
            drop_q  <= drop_d;
        end
    end

    assign bus.ready   = ready;
    assign bus.output1 = out_q;
    assign bus.done    = done_q;
    assign bus.drop    = drop_q;

endmodule
